// File: rtl/lsu_bus_arbiter_if.sv
// lsu_bus_arbiter_if -- bundle of every bus signal around lsu_bus_arbiter.
//   Requesters m0 (core LSU) and m1 (debug/DMA): req/addr/wren/wdata/bmask in,
//   gnt/rvalid out, shared o_rsp_rdata/o_rsp_err.
//   DMEM side: o_dmem_* strobe + payload out, i_dmem_rdata in (one cycle later).
//   I/O side : o_io_* strobe + payload out, i_io_ready/i_io_rdata in.
//   o_busy: arbiter is not idle.
// Signal names are seen from the arbiter: i_* flow into it, o_* flow out.
// slave  = arbiter side, master = environment (requesters + memories).
interface lsu_bus_arbiter_if;
  logic        i_m0_req,   i_m1_req;
  logic [31:0] i_m0_addr,  i_m1_addr;
  logic        i_m0_wren,  i_m1_wren;
  logic [31:0] i_m0_wdata, i_m1_wdata;
  logic [3:0]  i_m0_bmask, i_m1_bmask;
  logic        o_m0_gnt,   o_m1_gnt;
  logic        o_m0_rvalid, o_m1_rvalid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_dmem_valid, o_dmem_wren;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_bmask;
  logic [31:0] i_dmem_rdata;
  logic        o_io_valid, o_io_wren;
  logic [31:0] o_io_addr, o_io_wdata;
  logic [3:0]  o_io_bmask;
  logic        i_io_ready;
  logic [31:0] i_io_rdata;
  logic        o_busy;

  modport slave (
    input  i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_wren, i_m1_wren,
           i_m0_wdata, i_m1_wdata, i_m0_bmask, i_m1_bmask,
           i_dmem_rdata, i_io_ready, i_io_rdata,
    output o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_rsp_rdata, o_rsp_err,
           o_dmem_valid, o_dmem_wren, o_dmem_addr, o_dmem_wdata, o_dmem_bmask,
           o_io_valid, o_io_wren, o_io_addr, o_io_wdata, o_io_bmask, o_busy
  );

  modport master (
    output i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_wren, i_m1_wren,
           i_m0_wdata, i_m1_wdata, i_m0_bmask, i_m1_bmask,
           i_dmem_rdata, i_io_ready, i_io_rdata,
    input  o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_rsp_rdata, o_rsp_err,
           o_dmem_valid, o_dmem_wren, o_dmem_addr, o_dmem_wdata, o_dmem_bmask,
           o_io_valid, o_io_wren, o_io_addr, o_io_wdata, o_io_bmask, o_busy
  );
endinterface

// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter -- round-robin arbiter for the data-side bus (DMEM + I/O)
// shared by m0 (core LSU) and m1 (debug/DMA). One transaction in flight.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : lsu_bus_arbiter_if.slave (requesters, DMEM, I/O, o_busy)
// Region decode: DMEM addr[31:15]==0, I/O addr[31:16] in {1000,1001},
// everything else is unmapped and answered at once with an error.
// Optional: define LSU_ARB_TIMEOUT_EN to abort I/O accesses that wait
// TIMEOUT_CYCLES cycles without i_io_ready (response err=1).
module lsu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  lsu_bus_arbiter_if.slave  bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_DMEM_ACC, S_DMEM_RD, S_IO_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        mid;   // 0 = m0, 1 = m1
    logic [31:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } req_t;

  state_t      r_state;
  req_t        r_req;
  logic        r_last_gnt;
  logic        r_m0_rvalid, r_m1_rvalid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_dmem_valid, r_dmem_wren;
  logic [31:0] r_dmem_addr, r_dmem_wdata;
  logic [3:0]  r_dmem_bmask;
  logic        r_io_valid, r_io_wren;
  logic [31:0] r_io_addr, r_io_wdata;
  logic [3:0]  r_io_bmask;
`ifdef LSU_ARB_TIMEOUT_EN
  logic [31:0] r_cnt;
`endif

  logic w_idle, w_pick0, w_pick1, w_is_dmem, w_is_io;
  req_t w_sel;

  // Grant is combinational; reset is folded in so no grant leaks out while held.
  assign w_idle  = (r_state == S_IDLE) && i_reset;
  assign w_pick0 = bus.i_m0_req && (!bus.i_m1_req || r_last_gnt);
  assign w_pick1 = bus.i_m1_req && (!bus.i_m0_req || !r_last_gnt);

  always_comb begin
    w_sel = '0;
    if (w_pick1) w_sel = '{1'b1, bus.i_m1_addr, bus.i_m1_wren, bus.i_m1_wdata, bus.i_m1_bmask};
    else         w_sel = '{1'b0, bus.i_m0_addr, bus.i_m0_wren, bus.i_m0_wdata, bus.i_m0_bmask};
  end

  assign w_is_dmem = (w_sel.addr[31:15] == 17'd0);
  assign w_is_io   = (w_sel.addr[31:16] == 16'h1000) || (w_sel.addr[31:16] == 16'h1001);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_last_gnt   <= 1'b1;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_dmem_valid <= 1'b0;
      r_dmem_wren  <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_bmask <= '0;
      r_io_valid   <= 1'b0;
      r_io_wren    <= 1'b0;
      r_io_addr    <= '0;
      r_io_wdata   <= '0;
      r_io_bmask   <= '0;
`ifdef LSU_ARB_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick0 || w_pick1) begin
            r_req      <= w_sel;
            r_last_gnt <= w_pick1;
            if (w_is_dmem) begin
              r_state      <= S_DMEM_ACC;
              r_dmem_valid <= 1'b1;
              r_dmem_wren  <= w_sel.wren;
              r_dmem_addr  <= w_sel.addr;
              r_dmem_wdata <= w_sel.wdata;
              r_dmem_bmask <= w_sel.bmask;
            end else if (w_is_io) begin
              r_state    <= S_IO_WAIT;
              r_io_valid <= 1'b1;
              r_io_wren  <= w_sel.wren;
              r_io_addr  <= w_sel.addr;
              r_io_wdata <= w_sel.wdata;
              r_io_bmask <= w_sel.bmask;
`ifdef LSU_ARB_TIMEOUT_EN
              r_cnt      <= '0;
`endif
            end else begin
              r_state     <= S_RESP;
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
              r_m0_rvalid <= !w_sel.mid;
              r_m1_rvalid <= w_sel.mid;
            end
          end
        end
        S_DMEM_ACC: begin
          r_state      <= S_DMEM_RD;
          r_dmem_valid <= 1'b0;
          r_dmem_wren  <= 1'b0;
          r_dmem_addr  <= '0;
          r_dmem_wdata <= '0;
          r_dmem_bmask <= '0;
        end
        S_DMEM_RD: begin
          r_state     <= S_RESP;
          r_rsp_rdata <= r_req.wren ? 32'd0 : bus.i_dmem_rdata;
          r_rsp_err   <= 1'b0;
          r_m0_rvalid <= !r_req.mid;
          r_m1_rvalid <= r_req.mid;
        end
        S_IO_WAIT: begin
          if (bus.i_io_ready) begin
            r_state     <= S_RESP;
            r_io_valid  <= 1'b0;
            r_io_wren   <= 1'b0;
            r_io_addr   <= '0;
            r_io_wdata  <= '0;
            r_io_bmask  <= '0;
            r_rsp_rdata <= r_req.wren ? 32'd0 : bus.i_io_rdata;
            r_rsp_err   <= 1'b0;
            r_m0_rvalid <= !r_req.mid;
            r_m1_rvalid <= r_req.mid;
          end
`ifdef LSU_ARB_TIMEOUT_EN
          // r_cnt counts completed ready-less cycles; abort on the one that hits the limit.
          else if ((r_cnt + 32'd1) == TIMEOUT_CYCLES) begin
            r_state     <= S_RESP;
            r_io_valid  <= 1'b0;
            r_io_wren   <= 1'b0;
            r_io_addr   <= '0;
            r_io_wdata  <= '0;
            r_io_bmask  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_m0_rvalid <= !r_req.mid;
            r_m1_rvalid <= r_req.mid;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_m0_gnt     = w_idle && w_pick0;
  assign bus.o_m1_gnt     = w_idle && w_pick1;
  assign bus.o_m0_rvalid  = r_m0_rvalid;
  assign bus.o_m1_rvalid  = r_m1_rvalid;
  assign bus.o_rsp_rdata  = r_rsp_rdata;
  assign bus.o_rsp_err    = r_rsp_err;
  assign bus.o_dmem_valid = r_dmem_valid;
  assign bus.o_dmem_wren  = r_dmem_wren;
  assign bus.o_dmem_addr  = r_dmem_addr;
  assign bus.o_dmem_wdata = r_dmem_wdata;
  assign bus.o_dmem_bmask = r_dmem_bmask;
  assign bus.o_io_valid   = r_io_valid;
  assign bus.o_io_wren    = r_io_wren;
  assign bus.o_io_addr    = r_io_addr;
  assign bus.o_io_wdata   = r_io_wdata;
  assign bus.o_io_bmask   = r_io_bmask;
  assign bus.o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb_lsu_bus_arbiter -- directed bench for lsu_bus_arbiter: table of single
// transactions plus hand sequences for alternation, reset abort and timeout.
module tb_lsu_bus_arbiter;
`ifdef LSU_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  localparam int K_DMEM = 0, K_IO = 1, K_UNM = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bus_arbiter_if bus();
  lsu_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

  int npass = 0, ntot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // DMEM model: read data appears the cycle after the strobe.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.o_dmem_valid) begin
      bus.i_dmem_rdata <= mem[bus.o_dmem_addr[9:2]];
      if (bus.o_dmem_wren)
        for (int b = 0; b < 4; b++)
          if (bus.o_dmem_bmask[b]) mem[bus.o_dmem_addr[9:2]][8*b +: 8] <= bus.o_dmem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    int          kind;
    int          dly;     // I/O: ready-less cycles before ready
    logic [31:0] io_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic logic gnt_of(input int m);
    return (m == 0) ? bus.o_m0_gnt : bus.o_m1_gnt;
  endfunction
  function automatic logic rv_of(input int m);
    return (m == 0) ? bus.o_m0_rvalid : bus.o_m1_rvalid;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int m, input logic req, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] bm);
    if (m == 0) begin
      bus.i_m0_req = req; bus.i_m0_addr = a; bus.i_m0_wren = w; bus.i_m0_wdata = d; bus.i_m0_bmask = bm;
    end else begin
      bus.i_m1_req = req; bus.i_m1_addr = a; bus.i_m1_wren = w; bus.i_m1_wdata = d; bus.i_m1_bmask = bm;
    end
  endtask

  task automatic wait_gnt(output bit ok);
    int n = 0;
    #1;
    while (!(bus.o_m0_gnt || bus.o_m1_gnt) && n < 20) begin step(); #1; n++; end
    ok = bus.o_m0_gnt || bus.o_m1_gnt;
  endtask

  task automatic do_txn(input vec_t v);
    bit ok, tmo;
    int limit;
    drive(v.m, 1'b1, v.addr, v.wren, v.wdata, v.bmask);
    wait_gnt(ok);
    chk("gnt", {31'd0, gnt_of(v.m)}, 32'd1);
    chk("gnt_other", {31'd0, gnt_of(1 - v.m)}, 32'd0);
    step();
    drive(v.m, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
    case (v.kind)
      K_DMEM: begin
        chk("dmem_valid", {31'd0, bus.o_dmem_valid}, 32'd1);
        chk("dmem_addr", bus.o_dmem_addr, v.addr);
        chk("dmem_wren", {31'd0, bus.o_dmem_wren}, {31'd0, v.wren});
        chk("dmem_wdata", bus.o_dmem_wdata, v.wdata);
        chk("dmem_bmask", {28'd0, bus.o_dmem_bmask}, {28'd0, v.bmask});
        chk("dmem_io_excl", {31'd0, bus.o_io_valid}, 32'd0);
        step();
        chk("dmem_valid_1cyc", {31'd0, bus.o_dmem_valid}, 32'd0);
        chk("dmem_addr_idle0", bus.o_dmem_addr, 32'd0);
        chk("rvalid_early", {31'd0, rv_of(v.m)}, 32'd0);
        step();
      end
      K_IO: begin
        tmo = 1'b0; limit = v.dly + 1;
`ifdef LSU_ARB_TIMEOUT_EN
        if (v.dly + 1 > TMO) begin tmo = 1'b1; limit = TMO; end
`endif
        chk("io_addr", bus.o_io_addr, v.addr);
        chk("io_wren", {31'd0, bus.o_io_wren}, {31'd0, v.wren});
        chk("io_wdata", bus.o_io_wdata, v.wdata);
        for (int c = 0; c < limit; c++) begin
          chk("io_valid_held", {31'd0, bus.o_io_valid}, 32'd1);
          chk("io_dmem_excl", {31'd0, bus.o_dmem_valid}, 32'd0);
          bus.i_io_ready = !tmo && (c == v.dly);
          bus.i_io_rdata = bus.i_io_ready ? v.io_rd : 32'h0BAD_0BAD;
          step();
          bus.i_io_ready = 1'b0;
        end
        chk("io_valid_drop", {31'd0, bus.o_io_valid}, 32'd0);
        v.exp_rd  = tmo ? 32'd0 : v.exp_rd;
        v.exp_err = tmo;
      end
      default: begin
        chk("unm_dmem", {31'd0, bus.o_dmem_valid}, 32'd0);
        chk("unm_io", {31'd0, bus.o_io_valid}, 32'd0);
      end
    endcase
    chk("rvalid", {31'd0, rv_of(v.m)}, 32'd1);
    chk("rvalid_other", {31'd0, rv_of(1 - v.m)}, 32'd0);
    chk("rsp_rdata", bus.o_rsp_rdata, v.exp_rd);
    chk("rsp_err", {31'd0, bus.o_rsp_err}, {31'd0, v.exp_err});
    step();
    chk("rvalid_pulse", {31'd0, rv_of(v.m)}, 32'd0);
    chk("rsp_rdata_hold", bus.o_rsp_rdata, v.exp_rd);
  endtask

  vec_t vecs [9];
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok, any_rv;
    int exp_m;
    logic [31:0] exp_rd;
    vec_t t;
    //        m  addr           wren  wdata          bm    kind    dly io_rd        exp_rd         err
    vecs[0] = '{0, 32'h0000_0100, 1'b1, 32'hDEADBEEF, 4'hF, K_DMEM, 0, 32'h0,      32'h0,         1'b0};
    vecs[1] = '{0, 32'h0000_0100, 1'b0, 32'h0,        4'hF, K_DMEM, 0, 32'h0,      32'hDEADBEEF,  1'b0};
    vecs[2] = '{1, 32'h1001_0004, 1'b0, 32'h0,        4'hF, K_IO,   5, 32'hA5,     32'hA5,        1'b0};
    vecs[3] = '{0, 32'h2000_0000, 1'b0, 32'h0,        4'hF, K_UNM,  0, 32'h0,      32'h0,         1'b1};
    vecs[4] = '{1, 32'h0000_7FFC, 1'b1, 32'h12345678, 4'h3, K_DMEM, 0, 32'h0,      32'h0,         1'b0};
    vecs[5] = '{1, 32'h0000_7FFC, 1'b0, 32'h0,        4'hF, K_DMEM, 0, 32'h0,      32'hB1B15678,  1'b0};
    vecs[6] = '{0, 32'h0000_8000, 1'b0, 32'h0,        4'hF, K_UNM,  0, 32'h0,      32'h0,         1'b1};
    vecs[7] = '{0, 32'h1000_0000, 1'b1, 32'hCAFE0001, 4'hC, K_IO,   0, 32'hFFFF,   32'h0,         1'b0};
    vecs[8] = '{1, 32'h1002_0000, 1'b0, 32'h0,        4'hF, K_UNM,  0, 32'h0,      32'h0,         1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hA0A0A0A0;
    mem[8'hFF] = 32'hB1B1B1B1;
    bus.i_dmem_rdata = 32'h0;
    bus.i_io_ready = 1'b0; bus.i_io_rdata = 32'h0;
    drive(0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);

    // reset state
    #1;
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_gnt", {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.o_m1_rvalid, bus.o_m0_rvalid}, 32'd0);
    chk("rst_strobes", {30'd0, bus.o_io_valid, bus.o_dmem_valid}, 32'd0);
    chk("rst_rsp", {bus.o_rsp_rdata[30:0], bus.o_rsp_err}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;

    // both requesting continuously: m0 first, then strict alternation
    drive(0, 1'b1, 32'h0000_0100, 1'b0, 32'd0, 4'hF);
    drive(1, 1'b1, 32'h0000_7FFC, 1'b0, 32'd0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      exp_m  = i % 2;
      exp_rd = (exp_m == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
      wait_gnt(ok);
      chk("alt_gnt_m0", {31'd0, bus.o_m0_gnt}, {31'd0, exp_m == 0});
      chk("alt_gnt_m1", {31'd0, bus.o_m1_gnt}, {31'd0, exp_m == 1});
      repeat (3) step();
      chk("alt_rvalid_m0", {31'd0, bus.o_m0_rvalid}, {31'd0, exp_m == 0});
      chk("alt_rvalid_m1", {31'd0, bus.o_m1_rvalid}, {31'd0, exp_m == 1});
      chk("alt_rdata", bus.o_rsp_rdata, exp_rd);
      if (i == 7) begin
        drive(0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        drive(1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
      end
      step();
    end
    chk("alt_idle_after", {31'd0, bus.o_busy}, 32'd0);

    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // ready outside IO_WAIT is ignored
    bus.i_io_ready = 1'b1;
    any_rv = 1'b0;
    repeat (3) begin step(); any_rv |= bus.o_m0_rvalid | bus.o_m1_rvalid | bus.o_busy; end
    bus.i_io_ready = 1'b0;
    chk("ready_ignored", {31'd0, any_rv}, 32'd0);

    // reset in IO_WAIT aborts the access
    drive(1, 1'b1, 32'h1000_0008, 1'b0, 32'd0, 4'hF);
    wait_gnt(ok);
    chk("rst_seq_gnt", {31'd0, bus.o_m1_gnt}, 32'd1);
    step();
    drive(1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
    step();
    chk("rst_seq_io_valid", {31'd0, bus.o_io_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_io", {31'd0, bus.o_io_valid}, 32'd0);
    chk("rst_async_ioaddr", bus.o_io_addr, 32'd0);
    chk("rst_async_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_async_err", {31'd0, bus.o_rsp_err}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    bus.i_io_ready = 1'b1;
    any_rv = 1'b0;
    repeat (5) begin step(); any_rv |= bus.o_m0_rvalid | bus.o_m1_rvalid; end
    bus.i_io_ready = 1'b0;
    chk("rst_no_rvalid", {31'd0, any_rv}, 32'd0);
    t = '{0, 32'h2000_0000, 1'b0, 32'h0, 4'hF, K_UNM, 0, 32'h0, 32'h0, 1'b1};
    do_txn(t);

`ifdef LSU_ARB_TIMEOUT_EN
    t = '{0, 32'h1000_0010, 1'b0, 32'h0, 4'hF, K_IO, 100, 32'h0,  32'h0,  1'b1};
    do_txn(t);
    t = '{1, 32'h1001_0010, 1'b0, 32'h0, 4'hF, K_IO, 3,   32'h5A, 32'h5A, 1'b0};
    do_txn(t);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
